// File: rtl/ctrl_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_unit
// Description : Pipelined control unit for a 5-stage MIPS core. Decodes the
//               ID-stage instruction into a control bundle, carries it through
//               the ID/EX, EX/MEM and MEM/WB registers, and generates the
//               load-use stall, branch/jump flush and EX operand forwarding
//               selects. FWD_EN=0 replaces forwarding with RAW stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter int RA_W       = 5,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [RA_W-1:0]       id_rs,
  input  logic [RA_W-1:0]       id_rt,
  input  logic [RA_W-1:0]       id_rd,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  if_flush,
  output logic                  illegal,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [RA_W-1:0]       wb_dest,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_jump
);

  // Opcode encodings (instruction [31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  // R-type function encodings (instruction [5:0])
  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;

  // ALU control codes before zero-extension to ALU_CTRL_W
  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b10;
  localparam logic [1:0] c_FWD_WB  = 2'b01;

  // Raw decode (before valid/legal gating)
  logic       w_dec_legal;
  logic       w_dec_reg_write;
  logic       w_dec_mem_read;
  logic       w_dec_mem_write;
  logic       w_dec_branch;
  logic       w_dec_jump;
  logic       w_dec_alu_src;
  logic       w_dec_reg_dst;
  logic       w_dec_mem_to_reg;
  logic       w_dec_uses_rs;
  logic       w_dec_uses_rt;
  logic [2:0] w_dec_alu;

  // Gated ID bundle
  logic                  w_id_ok;
  logic                  w_id_uses_rs;
  logic                  w_id_uses_rt;
  logic [RA_W-1:0]       w_id_dest;
  logic [ALU_CTRL_W-1:0] w_id_alu;

  // Hazard terms
  logic w_load_use;
  logic w_ex_raw;
  logic w_mem_raw;
  logic w_raw_pending;
  logic w_stall_raw;
  logic w_insert_bubble;

  // ID/EX register
  logic                  r_ex_reg_write;
  logic                  r_ex_mem_read;
  logic                  r_ex_mem_write;
  logic                  r_ex_mem_to_reg;
  logic                  r_ex_alu_src;
  logic                  r_ex_reg_dst;
  logic                  r_ex_branch;
  logic [ALU_CTRL_W-1:0] r_ex_alu;
  logic [RA_W-1:0]       r_ex_rs;
  logic [RA_W-1:0]       r_ex_rt;
  logic [RA_W-1:0]       r_ex_dest;

  // EX/MEM register
  logic                  r_mem_mem_read;
  logic                  r_mem_mem_write;
  logic                  r_mem_reg_write;
  logic                  r_mem_mem_to_reg;
  logic [RA_W-1:0]       r_mem_dest;

  // MEM/WB register
  logic                  r_wb_reg_write;
  logic                  r_wb_mem_to_reg;
  logic [RA_W-1:0]       r_wb_dest;

  // Main decoder: opcode/funct to control bits and source usage
  always_comb begin
    w_dec_legal      = 1'b0;
    w_dec_reg_write  = 1'b0;
    w_dec_mem_read   = 1'b0;
    w_dec_mem_write  = 1'b0;
    w_dec_branch     = 1'b0;
    w_dec_jump       = 1'b0;
    w_dec_alu_src    = 1'b0;
    w_dec_reg_dst    = 1'b0;
    w_dec_mem_to_reg = 1'b0;
    w_dec_uses_rs    = 1'b0;
    w_dec_uses_rt    = 1'b0;
    w_dec_alu        = c_ALU_AND;
    case (opcode)
      c_OP_RTYPE: begin
        w_dec_reg_write = 1'b1;
        w_dec_reg_dst   = 1'b1;
        w_dec_uses_rs   = 1'b1;
        w_dec_uses_rt   = 1'b1;
        w_dec_legal     = 1'b1;
        case (funct)
          c_FN_ADD: w_dec_alu = c_ALU_ADD;
          c_FN_SUB: w_dec_alu = c_ALU_SUB;
          c_FN_AND: w_dec_alu = c_ALU_AND;
          c_FN_OR:  w_dec_alu = c_ALU_OR;
          c_FN_SLT: w_dec_alu = c_ALU_SLT;
          default:  w_dec_legal = 1'b0;
        endcase
      end
      c_OP_LW: begin
        w_dec_legal      = 1'b1;
        w_dec_reg_write  = 1'b1;
        w_dec_mem_read   = 1'b1;
        w_dec_alu_src    = 1'b1;
        w_dec_mem_to_reg = 1'b1;
        w_dec_uses_rs    = 1'b1;
        w_dec_alu        = c_ALU_ADD;
      end
      c_OP_SW: begin
        w_dec_legal     = 1'b1;
        w_dec_mem_write = 1'b1;
        w_dec_alu_src   = 1'b1;
        w_dec_uses_rs   = 1'b1;
        w_dec_uses_rt   = 1'b1;
        w_dec_alu       = c_ALU_ADD;
      end
      c_OP_ADDI: begin
        w_dec_legal     = 1'b1;
        w_dec_reg_write = 1'b1;
        w_dec_alu_src   = 1'b1;
        w_dec_uses_rs   = 1'b1;
        w_dec_alu       = c_ALU_ADD;
      end
      c_OP_BEQ: begin
        w_dec_legal   = 1'b1;
        w_dec_branch  = 1'b1;
        w_dec_uses_rs = 1'b1;
        w_dec_uses_rt = 1'b1;
        w_dec_alu     = c_ALU_SUB;
      end
      c_OP_J: begin
        w_dec_legal = 1'b1;
        w_dec_jump  = 1'b1;
      end
      default: w_dec_legal = 1'b0;
    endcase
  end

  // An invalid slot or an undecodable instruction behaves as a bubble.
  // A writer with reg_write=0 carries dest 0 so it can never match a source.
  assign w_id_ok      = id_valid & w_dec_legal;
  assign illegal      = id_valid & ~w_dec_legal;
  assign id_jump      = w_id_ok & w_dec_jump;
  assign w_id_uses_rs = w_id_ok & w_dec_uses_rs;
  assign w_id_uses_rt = w_id_ok & w_dec_uses_rt;
  assign w_id_dest    = (w_id_ok && w_dec_reg_write) ? (w_dec_reg_dst ? id_rd : id_rt) : '0;
  assign w_id_alu     = ALU_CTRL_W'(w_dec_alu);

  // Load in EX whose result an ID source needs: one stall covers both sources
  assign w_load_use = r_ex_mem_read && (r_ex_dest != '0) &&
                      ((w_id_uses_rs && (r_ex_dest == id_rs)) ||
                       (w_id_uses_rt && (r_ex_dest == id_rt)));

  // Pending writers in EX and MEM that an ID source depends on
  assign w_ex_raw  = r_ex_reg_write && (r_ex_dest != '0) &&
                     ((w_id_uses_rs && (r_ex_dest == id_rs)) ||
                      (w_id_uses_rt && (r_ex_dest == id_rt)));
  assign w_mem_raw = r_mem_reg_write && (r_mem_dest != '0) &&
                     ((w_id_uses_rs && (r_mem_dest == id_rs)) ||
                      (w_id_uses_rt && (r_mem_dest == id_rt)));

  // Without forwarding every RAW on an in-flight writer must wait it out
  assign w_raw_pending = (FWD_EN == 0) && (w_ex_raw || w_mem_raw);
  assign w_stall_raw   = w_load_use | w_raw_pending;

  // A taken branch squashes the stalled instruction, so it wins over stall
  assign stall           = w_stall_raw & ~branch_taken;
  assign if_flush        = branch_taken | (id_jump & ~w_stall_raw);
  assign w_insert_bubble = ~w_id_ok | w_stall_raw | branch_taken;

  // ID/EX register: load the decoded bundle or a bubble
  always_ff @(posedge clk) begin
    if (rst || w_insert_bubble) begin
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_reg_dst    <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_alu        <= '0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_dest       <= '0;
    end else begin
      r_ex_reg_write  <= w_dec_reg_write;
      r_ex_mem_read   <= w_dec_mem_read;
      r_ex_mem_write  <= w_dec_mem_write;
      r_ex_mem_to_reg <= w_dec_mem_to_reg;
      r_ex_alu_src    <= w_dec_alu_src;
      r_ex_reg_dst    <= w_dec_reg_dst;
      r_ex_branch     <= w_dec_branch;
      r_ex_alu        <= w_id_alu;
      r_ex_rs         <= w_dec_uses_rs ? id_rs : '0;
      r_ex_rt         <= w_dec_uses_rt ? id_rt : '0;
      r_ex_dest       <= w_id_dest;
    end
  end

  // EX/MEM register: always advances, stalls only hold the front end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_dest       <= '0;
    end else begin
      r_mem_mem_read   <= r_ex_mem_read;
      r_mem_mem_write  <= r_ex_mem_write;
      r_mem_reg_write  <= r_ex_reg_write;
      r_mem_mem_to_reg <= r_ex_mem_to_reg;
      r_mem_dest       <= r_ex_dest;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_dest       <= '0;
    end else begin
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_mem_to_reg <= r_mem_mem_to_reg;
      r_wb_dest       <= r_mem_dest;
    end
  end

  // EX operand selects; the younger EX/MEM result shadows MEM/WB
  generate
    if (FWD_EN != 0) begin : g_fwd
      always_comb begin
        fwd_a = c_FWD_RF;
        fwd_b = c_FWD_RF;
        if (r_mem_reg_write && (r_mem_dest != '0) && (r_mem_dest == r_ex_rs)) begin
          fwd_a = c_FWD_MEM;
        end else if (r_wb_reg_write && (r_wb_dest != '0) && (r_wb_dest == r_ex_rs)) begin
          fwd_a = c_FWD_WB;
        end
        if (r_mem_reg_write && (r_mem_dest != '0) && (r_mem_dest == r_ex_rt)) begin
          fwd_b = c_FWD_MEM;
        end else if (r_wb_reg_write && (r_wb_dest != '0) && (r_wb_dest == r_ex_rt)) begin
          fwd_b = c_FWD_WB;
        end
      end
    end else begin : g_no_fwd
      assign fwd_a = c_FWD_RF;
      assign fwd_b = c_FWD_RF;
    end
  endgenerate

  assign ex_alu_control = r_ex_alu;
  assign ex_alu_src     = r_ex_alu_src;
  assign ex_reg_dst     = r_ex_reg_dst;
  assign ex_branch      = r_ex_branch;
  assign mem_mem_read   = r_mem_mem_read;
  assign mem_mem_write  = r_mem_mem_write;
  assign wb_reg_write   = r_wb_reg_write;
  assign wb_mem_to_reg  = r_wb_mem_to_reg;
  assign wb_dest        = r_wb_dest;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe_unit
// Description : Scoreboard bench for ctrl_pipe_unit. Directed vectors push
//               hand-computed expectations tagged with the cycle they apply
//               to; a negedge monitor pops and compares them. A second
//               instance with FWD_EN=0 shares the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;

    localparam int S_STALL = 0,  S_FLUSH = 1,  S_ILL = 2,    S_JUMP = 3;
    localparam int S_FWDA  = 4,  S_FWDB  = 5,  S_EXALU = 6,  S_EXSRC = 7;
    localparam int S_EXDST = 8,  S_EXBR  = 9,  S_MRD = 10,   S_MWR = 11;
    localparam int S_WBRW  = 12, S_WBM2R = 13, S_WBDEST = 14;
    localparam int S_NF_STALL = 15, S_NF_FWDA = 16, S_NF_FWDB = 17, S_NF_EXALU = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       branch_taken;

    logic       stall, if_flush, illegal, id_jump;
    logic [2:0] ex_alu_control;
    logic       ex_alu_src, ex_reg_dst, ex_branch;
    logic       mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dest;
    logic [1:0] fwd_a, fwd_b;

    logic       nf_stall, nf_if_flush, nf_illegal, nf_id_jump;
    logic [2:0] nf_ex_alu_control;
    logic       nf_ex_alu_src, nf_ex_reg_dst, nf_ex_branch;
    logic       nf_mem_mem_read, nf_mem_mem_write, nf_wb_reg_write, nf_wb_mem_to_reg;
    logic [4:0] nf_wb_dest;
    logic [1:0] nf_fwd_a, nf_fwd_b;

    ctrl_pipe_unit #(.ALU_CTRL_W(3), .RA_W(5), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(stall), .if_flush(if_flush), .illegal(illegal),
        .ex_alu_control(ex_alu_control), .ex_alu_src(ex_alu_src),
        .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b), .id_jump(id_jump)
    );

    ctrl_pipe_unit #(.ALU_CTRL_W(3), .RA_W(5), .FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(nf_stall), .if_flush(nf_if_flush), .illegal(nf_illegal),
        .ex_alu_control(nf_ex_alu_control), .ex_alu_src(nf_ex_alu_src),
        .ex_reg_dst(nf_ex_reg_dst), .ex_branch(nf_ex_branch),
        .mem_mem_read(nf_mem_mem_read), .mem_mem_write(nf_mem_mem_write),
        .wb_reg_write(nf_wb_reg_write), .wb_mem_to_reg(nf_wb_mem_to_reg),
        .wb_dest(nf_wb_dest), .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .id_jump(nf_id_jump)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    sig;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic int get_sig(input int s);
        case (s)
            S_STALL:    return 32'(stall);
            S_FLUSH:    return 32'(if_flush);
            S_ILL:      return 32'(illegal);
            S_JUMP:     return 32'(id_jump);
            S_FWDA:     return 32'(fwd_a);
            S_FWDB:     return 32'(fwd_b);
            S_EXALU:    return 32'(ex_alu_control);
            S_EXSRC:    return 32'(ex_alu_src);
            S_EXDST:    return 32'(ex_reg_dst);
            S_EXBR:     return 32'(ex_branch);
            S_MRD:      return 32'(mem_mem_read);
            S_MWR:      return 32'(mem_mem_write);
            S_WBRW:     return 32'(wb_reg_write);
            S_WBM2R:    return 32'(wb_mem_to_reg);
            S_WBDEST:   return 32'(wb_dest);
            S_NF_STALL: return 32'(nf_stall);
            S_NF_FWDA:  return 32'(nf_fwd_a);
            S_NF_FWDB:  return 32'(nf_fwd_b);
            S_NF_EXALU: return 32'(nf_ex_alu_control);
            default:    return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        int act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = get_sig(sb[i].sig);
                n_total++;
                if (act == sb[i].exp) n_pass++;
                else $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                              sb[i].name, cyc, act, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic chk(input int dc, input int s, input int v, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.sig  = s;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic bt);
        id_valid     = v;
        opcode       = op;
        funct        = fn;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        branch_taken = bt;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        tick(); tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (stall == 1'b0) n_pass++;
        else $display("FAIL d_rst_stall cyc=%0d actual=%0d required=0", cyc, stall);
        n_total++;
        if (if_flush == 1'b0) n_pass++;
        else $display("FAIL d_rst_flush cyc=%0d actual=%0d required=0", cyc, if_flush);
        n_total++;
        if (illegal == 1'b0) n_pass++;
        else $display("FAIL d_rst_illegal cyc=%0d actual=%0d required=0", cyc, illegal);
        n_total++;
        if (fwd_a == 2'b00) n_pass++;
        else $display("FAIL d_rst_fwd_a cyc=%0d actual=%0d required=0", cyc, fwd_a);
        n_total++;
        if (fwd_b == 2'b00) n_pass++;
        else $display("FAIL d_rst_fwd_b cyc=%0d actual=%0d required=0", cyc, fwd_b);
        n_total++;
        if (wb_dest == 5'd0) n_pass++;
        else $display("FAIL d_rst_wb_dest cyc=%0d actual=%0d required=0", cyc, wb_dest);
        chk(0, S_STALL, 0, "rst_stall");   chk(0, S_FLUSH, 0, "rst_flush");
        chk(0, S_ILL, 0, "rst_illegal");   chk(0, S_JUMP, 0, "rst_jump");
        chk(0, S_FWDA, 0, "rst_fwd_a");    chk(0, S_FWDB, 0, "rst_fwd_b");
        chk(0, S_EXALU, 0, "rst_ex_alu");  chk(0, S_EXDST, 0, "rst_ex_dst");
        chk(0, S_EXSRC, 0, "rst_ex_src");  chk(0, S_MRD, 0, "rst_mem_rd");
        chk(0, S_MWR, 0, "rst_mem_wr");    chk(0, S_WBRW, 0, "rst_wb_rw");
        chk(0, S_WBDEST, 0, "rst_wb_dest"); chk(0, S_NF_STALL, 0, "rst_nf_stall");
        tick();

        drive(1'b1, OP_R, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        chk(0, S_ILL, 0, "add_illegal");  chk(0, S_STALL, 0, "add_stall");
        chk(1, S_EXALU, 2, "add_ex_alu"); chk(1, S_EXDST, 1, "add_ex_dst");
        chk(1, S_EXSRC, 0, "add_ex_src"); chk(2, S_MRD, 0, "add_mem_rd");
        chk(3, S_WBRW, 1, "add_wb_rw");   chk(3, S_WBDEST, 3, "add_wb_dest");
        chk(3, S_WBM2R, 0, "add_wb_m2r");
        tick();
        n_total++;
        if (ex_alu_control == 3'b010) n_pass++;
        else $display("FAIL d_add_ex_alu cyc=%0d actual=%0d required=2", cyc, ex_alu_control);
        n_total++;
        if (ex_reg_dst == 1'b1) n_pass++;
        else $display("FAIL d_add_ex_dst cyc=%0d actual=%0d required=1", cyc, ex_reg_dst);
        drain();

        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0);
        chk(0, S_STALL, 0, "lw_stall");
        tick();
        drive(1'b1, OP_R, FN_ADD, 5'd4, 5'd2, 5'd6, 1'b0);
        #1;
        n_total++;
        if (stall == 1'b1) n_pass++;
        else $display("FAIL d_lu_stall cyc=%0d actual=%0d required=1", cyc, stall);
        chk(0, S_STALL, 1, "lu_stall");   chk(0, S_FLUSH, 0, "lu_flush");
        chk(0, S_EXALU, 2, "lw_ex_alu");  chk(0, S_EXSRC, 1, "lw_ex_src");
        tick();
        chk(0, S_STALL, 0, "lu_release"); chk(0, S_EXALU, 0, "lu_bubble_alu");
        chk(0, S_EXSRC, 0, "lu_bubble_src"); chk(0, S_MRD, 1, "lw_mem_rd");
        tick();
        idle();
        chk(0, S_FWDA, 1, "lu_fwd_a");    chk(0, S_FWDB, 0, "lu_fwd_b");
        chk(0, S_EXDST, 1, "lu_add_ex");  chk(0, S_WBM2R, 1, "lw_wb_m2r");
        chk(0, S_WBRW, 1, "lw_wb_rw");    chk(0, S_WBDEST, 4, "lw_wb_dest");
        tick();
        drain();

        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, FN_ADD, 5'd7, 5'd7, 5'd8, 1'b0);
        chk(0, S_STALL, 1, "lu2_stall");
        tick();
        chk(0, S_STALL, 0, "lu2_single");
        tick();
        drain();

        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_SW, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0);
        chk(0, S_STALL, 1, "lu_sw_rt_stall");
        tick();
        chk(0, S_STALL, 0, "lu_sw_release");
        tick();
        idle();
        chk(0, S_FWDB, 1, "sw_fwd_b");    chk(1, S_MWR, 1, "sw_mem_wr");
        tick();
        drain();

        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_ADDI, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0);
        chk(0, S_STALL, 0, "addi_rt_nostall");
        tick();
        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, FN_ADD, 5'd0, 5'd0, 5'd2, 1'b0);
        chk(0, S_STALL, 0, "lu_r0_nostall");
        tick();
        drain();

        drive(1'b1, OP_R, FN_ADD, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        drive(1'b1, OP_R, FN_SUB, 5'd5, 5'd5, 5'd7, 1'b0);
        chk(0, S_STALL, 0, "fwd_nostall");
        tick();
        idle();
        chk(0, S_FWDA, 2, "fwd_a_mem");   chk(0, S_FWDB, 2, "fwd_b_mem");
        chk(0, S_EXALU, 6, "sub_ex_alu");
        tick();
        drain();

        drive(1'b1, OP_R, FN_ADD, 5'd1, 5'd2, 5'd8, 1'b0);
        tick();
        drive(1'b1, OP_R, FN_OR, 5'd1, 5'd2, 5'd8, 1'b0);
        tick();
        drive(1'b1, OP_R, FN_AND, 5'd8, 5'd9, 5'd10, 1'b0);
        tick();
        idle();
        chk(0, S_FWDA, 2, "fwd_prio");    chk(0, S_FWDB, 0, "fwd_prio_b");
        chk(0, S_EXALU, 0, "and_ex_alu");
        tick();
        drain();

        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, FN_ADD, 5'd4, 5'd2, 5'd3, 1'b1);
        chk(0, S_STALL, 0, "bt_stall");   chk(0, S_FLUSH, 1, "bt_flush");
        tick();
        idle();
        chk(0, S_EXALU, 0, "bt_bubble_alu"); chk(0, S_EXDST, 0, "bt_bubble_dst");
        chk(0, S_MRD, 1, "bt_lw_advances");
        tick();
        drain();

        drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
        chk(1, S_EXBR, 1, "beq_ex_br");   chk(1, S_EXALU, 6, "beq_ex_alu");
        tick();
        drive(1'b1, OP_R, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        chk(0, S_FLUSH, 1, "beq_flush");  chk(0, S_STALL, 0, "beq_stall");
        tick();
        idle();
        chk(0, S_EXBR, 0, "beq_bubble_br"); chk(0, S_EXDST, 0, "beq_bubble_dst");
        tick();
        drain();

        drive(1'b1, OP_J, 6'd0, 5'd3, 5'd4, 5'd5, 1'b0);
        chk(0, S_JUMP, 1, "j_jump");      chk(0, S_FLUSH, 1, "j_flush");
        chk(0, S_ILL, 0, "j_illegal");    chk(1, S_EXALU, 0, "j_ex_alu");
        chk(3, S_WBRW, 0, "j_wb_rw");
        tick();
        idle();
        chk(0, S_JUMP, 0, "j_gone");      chk(0, S_FLUSH, 0, "j_flush_gone");
        tick();
        drain();

        drive(1'b1, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        chk(0, S_ILL, 1, "ill_opcode");   chk(1, S_EXDST, 0, "ill_ex_dst");
        chk(3, S_WBRW, 0, "ill_wb_rw");   chk(3, S_WBDEST, 0, "ill_wb_dest");
        tick();
        drive(1'b1, OP_R, 6'b000000, 5'd1, 5'd2, 5'd3, 1'b0);
        chk(0, S_ILL, 1, "ill_funct");    chk(1, S_EXDST, 0, "ill_funct_ex");
        chk(3, S_WBRW, 0, "ill_funct_wb");
        tick();
        drive(1'b0, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        chk(0, S_ILL, 0, "ill_invalid");
        tick();
        drain();

        drive(1'b1, OP_R, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        chk(1, S_EXALU, 2, "mr_ex_loaded");
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(0, S_EXDST, 0, "mr_ex_dst");  chk(0, S_EXALU, 0, "mr_ex_alu");
        chk(1, S_WBRW, 0, "mr_wb_rw");    chk(1, S_WBDEST, 0, "mr_wb_dest");
        tick();
        drain();

        drive(1'b1, OP_R, FN_ADD, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        drive(1'b1, OP_R, FN_SUB, 5'd5, 5'd5, 5'd7, 1'b0);
        chk(0, S_NF_STALL, 1, "nf_stall_ex"); chk(0, S_NF_FWDA, 0, "nf_fwd_a_ex");
        tick();
        chk(0, S_NF_STALL, 1, "nf_stall_mem"); chk(0, S_NF_EXALU, 0, "nf_bubble");
        tick();
        chk(0, S_NF_STALL, 0, "nf_release");
        tick();
        idle();
        chk(0, S_NF_EXALU, 6, "nf_sub_ex");   chk(0, S_NF_FWDA, 0, "nf_fwd_a");
        chk(0, S_NF_FWDB, 0, "nf_fwd_b");
        tick();
        drain();
        tick();

        foreach (sb[i]) begin
            n_total++;
            $display("FAIL %s cyc=%0d actual=unchecked required=%0d", sb[i].name, sb[i].cyc, sb[i].exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the 5-stage MIPS core, successor to the flat combinational decoder. Decodes the ID-stage instruction, carries the control bundle through ID/EX, EX/MEM and MEM/WB registers, and detects hazards: load-use stall, branch/jump flush, and EX/MEM/WB forwarding selects. A mode parameter selects forwarding or stall-only RAW handling.

## Interface
- `ALU_CTRL_W`, default 3: width of the ALU control field. Encodings are zero-extended; must be ≥ 3.
- `RA_W`, default 5: register-address width.
- `FWD_EN`, default 1: 1 = forwarding enabled; 0 = every RAW hazard on a pending writer stalls.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `opcode` input 6: instruction [31:26].
- `funct` input 6: instruction [5:0].
- `id_rs`, `id_rt`, `id_rd` input RA_W: source/destination fields of the ID instruction.
- `branch_taken` input 1: EX-stage BEQ resolved taken.
- `stall` output 1: hold PC and IF/ID (combinational).
- `if_flush` output 1: squash IF/ID (combinational).
- `illegal` output 1: valid ID opcode/funct not decodable (combinational).
- `ex_alu_control` output ALU_CTRL_W.
- `ex_alu_src`, `ex_reg_dst`, `ex_branch` output 1 each.
- `mem_mem_read`, `mem_mem_write` output 1 each.
- `wb_reg_write`, `wb_mem_to_reg` output 1 each.
- `wb_dest` output RA_W.
- `fwd_a`, `fwd_b` output 2: EX operand selects. 00 = register file, 10 = EX/MEM, 01 = MEM/WB (combinational).
- `id_jump` output 1: ID holds J (combinational).

## Operation
- Decode table (signals reg_write, mem_read, mem_write, branch, jump, alu_src, reg_dst, mem_to_reg, alu):
  - R-type (opcode 000000): reg_write=1, reg_dst=1. funct sets alu: ADD 100000→010, SUB 100010→110, AND 100100→000, OR 100101→001, SLT 101010→111. Any other funct is illegal.
  - LW 100011: reg_write, mem_read, alu_src, mem_to_reg; alu 010.
  - SW 101011: mem_write, alu_src; alu 010.
  - ADDI 001000: reg_write, alu_src; alu 010.
  - BEQ 000100: branch; alu 110.
  - J 000010: jump. Resolved in ID.
  - Any other opcode is illegal.
- An illegal instruction or `id_valid=0` decodes to a bubble: all bundle bits 0, dest 0.
- Destination: dest = reg_dst ? rd : rt. If reg_write=0 or dest=0, the writer is treated as none.
- Pipeline registers: ID/EX holds the full bundle plus rs, rt, dest. EX/MEM holds mem_read, mem_write, reg_write, mem_to_reg, dest. MEM/WB holds reg_write, mem_to_reg, dest.
- Load-use hazard: ID/EX mem_read=1, ID/EX dest≠0, and dest equals id_rs, or id_rt when the ID instruction reads rt (R-type, SW, BEQ).
  - Response: stall=1 and a bubble is written into ID/EX.
- FWD_EN=0: stall is also raised when a pending writer in ID/EX or EX/MEM has dest≠0 matching a used source.
- Forwarding (FWD_EN=1), fwd_a for ID/EX rs:
  - 10 if EX/MEM reg_write, EX/MEM dest≠0, and dest==rs.
  - Otherwise 01 if the same conditions hold for MEM/WB.
  - Otherwise 00. EX/MEM has priority.
  - fwd_b: same rules for rt.
- FWD_EN=0: fwd_a = fwd_b = 00.
- Flush:
  - branch_taken → if_flush=1, bubble into ID/EX, stall forced 0.
  - id_jump (and not stalled) → if_flush=1. The J bundle itself is a bubble downstream.
  - Priority: rst > branch_taken > stall > normal.

## Timing
- Reset: all pipeline registers cleared to bubble on the first rising edge with rst=1. Every registered output reads 0; combinational outputs then read 0 for id_valid=0. Reset mid-operation discards all in-flight state.
- Latency: decode in ID → ex_* visible 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Stall holds IF/ID for exactly 1 cycle per load-use; EX/MEM and MEM/WB keep advancing.
- A stall and branch_taken in the same cycle resolve as flush. The stalled instruction is squashed; no stall.
- Simultaneous hazards on rs and rt produce one stall cycle, not two.
- MEM/WB writes at the same edge register-file writes complete; no WB→ID bypass here.

## Test plan
- Reset then idle: rst=1 for 2 cycles → all outputs 0, fwd 00.
- ADD (op 000000, funct 100000, rd=3) → after 1 clk ex_alu_control=010, ex_reg_dst=1; after 3 clk wb_reg_write=1, wb_dest=3.
- LW rt=4, then ADD rs=4 → stall=1 for one cycle, bubble in ID/EX. Next cycle fwd_a=01 on the ADD.
- ADD rd=5, then SUB rs=5 rt=5 → fwd_a=fwd_b=10, no stall.
- Same sequence with FWD_EN=0 → stall for 2 cycles, fwd 00.
- BEQ with branch_taken=1 in its EX cycle while ID holds a load-use consumer → if_flush=1, stall=0, ex_* bubble. J in ID → id_jump=1, if_flush=1.
- Illegal (opcode 111111) → illegal=1; bubble reaches wb after 3 clk with wb_reg_write=0.
